// File: rtl/vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// vend_dispense_ctrl
//
// Consumer of the vending FSM's sale-result interface. Each rising edge of
// vend_vld is one completed sale; it is queued (with its change-owed bit) and
// later serviced as one product-motor run, optionally followed by a gap and a
// single change-coin hopper pulse.
//
// Handshake: vend_vld is a level, not a valid/ready pair. An order is taken
// on the first cycle vend_vld is seen high (vend_vld & ~vld_d); there is no
// back-pressure. If the queue is full and nothing pops that cycle, the order
// is lost and ovf is set.
//
// Optional feature: define DROP_SENSE_EN to end the motor run on drop_det
// (with a TMO_CYC-cycle timeout that sets fault and skips the hopper).
// Without it the motor runs a fixed MOTOR_CYC cycles, drop_det is ignored
// and fault is tied low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   vend_vld     sale valid level
//   vend_chg     change-owed flag, sampled with the vend_vld rise
//   drop_det     product drop sensor (DROP_SENSE_EN only)
//   err_clr      synchronous clear of ovf/fault (a same-cycle set wins)
//   motor_on     product motor drive
//   coin_out     hopper drive, one coin per pulse
//   vend_done    one-cycle pulse per completed order
//   busy         order in service or queued
//   pend_cnt     queued orders, excluding the one in service
//   ovf          sticky: order lost to a full queue
//   fault        sticky: drop-sensor timeout
//   dbg_state    current FSM state encoding
// -----------------------------------------------------------------------------
module vend_dispense_ctrl #(
    parameter int DEPTH     = 4,
    parameter int MOTOR_CYC = 8,
    parameter int GAP_CYC   = 2,
    parameter int HOP_CYC   = 4,
    parameter int TMO_CYC   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vend_vld,
    input  logic                     vend_chg,
    input  logic                     drop_det,
    input  logic                     err_clr,
    output logic                     motor_on,
    output logic                     coin_out,
    output logic                     vend_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    output logic                     ovf,
    output logic                     fault,
    output logic [2:0]               dbg_state
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNTW  = AW + 1;
    localparam int MAX_A = (MOTOR_CYC > GAP_CYC) ? MOTOR_CYC : GAP_CYC;
    localparam int MAX_B = (HOP_CYC > TMO_CYC) ? HOP_CYC : TMO_CYC;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXC + 1);

`ifdef DROP_SENSE_EN
    localparam logic [CW-1:0] MOTOR_LOAD = CW'(TMO_CYC - 1);
`else
    localparam logic [CW-1:0] MOTOR_LOAD = CW'(MOTOR_CYC - 1);
`endif
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] HOP_LOAD = CW'(HOP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOTOR  = 3'd1,
        S_GAP    = 3'd2,
        S_HOPPER = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     ctr, ctr_nxt;
    logic              chg_r, chg_nxt;
    logic              vld_d;

    logic [DEPTH-1:0]  mem;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   cnt;

    logic              order, full, pop, push, lost;

    // ---------------- order detect and queue ----------------
    assign order = vend_vld & ~vld_d;
    assign full  = (cnt == CNTW'(DEPTH));
    assign pop   = (state == S_IDLE) && (cnt != '0);
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push  = order & (~full | pop);
    assign lost  = order & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d  <= 1'b0;
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            vld_d <= vend_vld;
            if (push) begin
                mem[wr_ptr] <= vend_chg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNTW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNTW'(1);
            end
            ovf <= (ovf & ~err_clr) | lost;
        end
    end

    // ---------------- dispense FSM ----------------
`ifdef DROP_SENSE_EN
    logic fault_set;
`else
    logic drop_unused;
    assign drop_unused = drop_det;
`endif

    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        chg_nxt   = chg_r;
`ifdef DROP_SENSE_EN
        fault_set = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (cnt != '0) begin
                    state_nxt = S_MOTOR;
                    chg_nxt   = mem[rd_ptr];
                    ctr_nxt   = MOTOR_LOAD;
                end
            end
            S_MOTOR: begin
`ifdef DROP_SENSE_EN
                // Drop is checked before the timeout, so a drop on the last
                // allowed cycle still counts as a good vend.
                if (drop_det) begin
                    state_nxt = chg_r ? S_GAP : S_DONE;
                    ctr_nxt   = GAP_LOAD;
                end else if (ctr == '0) begin
                    fault_set = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    ctr_nxt = ctr - CW'(1);
                end
`else
                if (ctr == '0) begin
                    state_nxt = chg_r ? S_GAP : S_DONE;
                    ctr_nxt   = GAP_LOAD;
                end else begin
                    ctr_nxt = ctr - CW'(1);
                end
`endif
            end
            S_GAP: begin
                if (ctr == '0) begin
                    state_nxt = S_HOPPER;
                    ctr_nxt   = HOP_LOAD;
                end else begin
                    ctr_nxt = ctr - CW'(1);
                end
            end
            S_HOPPER: begin
                if (ctr == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    ctr_nxt = ctr - CW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Drives are registered from the next state so they line up exactly with
    // the state they belong to and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ctr       <= '0;
            chg_r     <= 1'b0;
            motor_on  <= 1'b0;
            coin_out  <= 1'b0;
            vend_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctr       <= ctr_nxt;
            chg_r     <= chg_nxt;
            motor_on  <= (state_nxt == S_MOTOR);
            coin_out  <= (state_nxt == S_HOPPER);
            vend_done <= (state_nxt == S_DONE);
        end
    end

`ifdef DROP_SENSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else begin
            fault <= (fault & ~err_clr) | fault_set;
        end
    end
`else
    assign fault = 1'b0;
`endif

    assign busy      = (state != S_IDLE) | (cnt != '0);
    assign pend_cnt  = cnt;
    assign dbg_state = state;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_ctrl
//
// Reference model: a queue of pending change bits (ord_q) and, for the order
// in service, a precomputed per-cycle timeline of expected drives (exp_q).
// When the service timeline runs dry the controller is idle for one cycle,
// at whose closing edge the next pending order starts. Directed scenarios
// follow the test plan; a random phase follows.
// -----------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

    localparam int DEPTH     = 4;
    localparam int MOTOR_CYC = 8;
    localparam int GAP_CYC   = 2;
    localparam int HOP_CYC   = 4;
    localparam int TMO_CYC   = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       vend_vld, vend_chg, drop_det, err_clr;
    logic       motor_on, coin_out, vend_done, busy, ovf, fault;
    logic [2:0] pend_cnt;
    logic [2:0] dbg_state;

    vend_dispense_ctrl #(
        .DEPTH(DEPTH), .MOTOR_CYC(MOTOR_CYC), .GAP_CYC(GAP_CYC),
        .HOP_CYC(HOP_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vend_vld(vend_vld), .vend_chg(vend_chg),
        .drop_det(drop_det), .err_clr(err_clr),
        .motor_on(motor_on), .coin_out(coin_out), .vend_done(vend_done),
        .busy(busy), .pend_cnt(pend_cnt), .ovf(ovf), .fault(fault),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    // exp_q entry bits: [4] motor, [3] coin, [2] done, [1] drop_det this
    // cycle, [0] fault is set at the end of this cycle.
    logic [4:0] exp_q[$];
    logic [0:0] ord_q[$];
    logic       prev_vld;
    logic       ovf_m, fault_m;
    logic       cur_coin;
    int         drop_plan;   // -1 random, 0 never, k>0 drop on motor cycle k
    int         n_checks, n_fail, n_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_order(input logic chg);
        int  d;
        int  mlen;
        logic tmo;
        logic [4:0] e;
`ifdef DROP_SENSE_EN
        d    = (drop_plan >= 0) ? drop_plan : int'($urandom_range(0, TMO_CYC + 4));
        tmo  = (d == 0) || (d > TMO_CYC);
        mlen = tmo ? TMO_CYC : d;
`else
        d    = 0;
        tmo  = 1'b0;
        mlen = MOTOR_CYC;
`endif
        for (int i = 0; i < mlen; i++) begin
            e = 5'b10000;
            if (i == mlen - 1) begin
`ifdef DROP_SENSE_EN
                if (tmo) e[0] = 1'b1;
                else     e[1] = 1'b1;
`endif
            end
            exp_q.push_back(e);
        end
        if (!tmo && chg) begin
            for (int i = 0; i < GAP_CYC; i++) exp_q.push_back(5'b00000);
            for (int i = 0; i < HOP_CYC; i++) exp_q.push_back(5'b01000);
        end
        exp_q.push_back(5'b00100);
        if (d < 0) n_done = n_done; // d only matters with the drop sensor
    endtask

    // One clock: check the cycle the last edge produced, drive inputs for the
    // next edge, and advance the model across that edge.
    task automatic tick(input logic vld, input logic chg, input logic clr);
        logic [4:0] e;
        logic       has, order, ovf_set;
        @(negedge clk);
        has = (exp_q.size() != 0);
        e   = has ? exp_q.pop_front() : 5'b00000;
        check("motor_on", motor_on, e[4]);
        check("coin_out", coin_out, e[3]);
        check("vend_done", vend_done, e[2]);
        check("busy", busy, has || (ord_q.size() != 0));
        check("pend_cnt", pend_cnt, ord_q.size());
        check("ovf", ovf, ovf_m);
        check("fault", fault, fault_m);
        check("no_overlap", motor_on & coin_out, 0);
        if (vend_done) n_done++;
        cur_coin = e[3];
`ifdef DROP_SENSE_EN
        drop_det = e[1];
`else
        drop_det = 1'($urandom_range(0, 1));
`endif
        vend_vld = vld;
        vend_chg = chg;
        err_clr  = clr;
        order    = vld && !prev_vld;
        prev_vld = vld;
        ovf_set  = 1'b0;
        if (!has && ord_q.size() != 0) start_order(ord_q.pop_front());
        if (order) begin
            if (ord_q.size() < DEPTH) ord_q.push_back(chg);
            else                      ovf_set = 1'b1;
        end
        ovf_m   = (ovf_m && !clr) || ovf_set;
        fault_m = (fault_m && !clr) || e[0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        ord_q.delete();
        prev_vld = 1'b0;
        ovf_m    = 1'b0;
        fault_m  = 1'b0;
        cur_coin = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_done    = 0;
        drop_plan = -1;
        vend_vld  = 1'b0;
        vend_chg  = 1'b0;
        drop_det  = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_motor_on", motor_on, 0);
        check("rst_coin_out", coin_out, 0);
        check("rst_vend_done", vend_done, 0);
        check("rst_busy", busy, 0);
        check("rst_pend_cnt", pend_cnt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_fault", fault, 0);
        rst_n = 1'b1;

        // Single short order, no change.
        drop_plan = 3;
        tick(1'b1, 1'b0, 1'b0);
        idle(20);

        // Long vend_vld level with change owed: exactly one order.
        n_done = 0;
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0);
        idle(25);
        check("one_order_done_count", n_done, 1);

`ifdef DROP_SENSE_EN
        // Drop sensor never fires: timeout, fault, no hopper.
        drop_plan = 0;
        tick(1'b1, 1'b1, 1'b0);
        idle(40);
        check("timeout_fault", fault, 1);
        tick(1'b0, 1'b0, 1'b1);
        idle(2);
`endif

        // Three more rises during a dispense, distinct change bits.
        drop_plan = -1;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
        idle(200);

        // Six rapid rises: one in service, four queued, one lost.
`ifdef DROP_SENSE_EN
        drop_plan = 0;
`endif
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        check("ovf_sticky", ovf, 1);
        tick(1'b0, 1'b0, 1'b1);
        idle(300);
        check("burst_done_count", n_done, 5);
        tick(1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset mid-hopper with orders still queued.
        drop_plan = 3;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60 && !cur_coin; i++) tick(1'b0, 1'b0, 1'b0);
        check("reached_hopper", cur_coin, 1);
        vend_vld = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_coin_out", coin_out, 0);
        check("async_motor_on", motor_on, 0);
        check("async_pend_cnt", pend_cnt, 0);
        check("async_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        idle(20);
        check("no_done_after_reset", n_done, 0);

        // Random phase.
        drop_plan = -1;
        begin
            logic v;
            v = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) v = ~v;
                tick(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            end
        end
        idle(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
